lcd_status_reader: RTL
======================

# lcd_status_reader

Read-cycle engine for the 16x2 HD44780-compatible LCD module: executes timed read cycles (RW=1) to fetch the busy flag and address counter (RS=0) or a DDRAM/CGRAM data byte (RS=1). It sits beside the LCD write controller on the LCD bus. The write controller calls it to poll the busy flag instead of relying on fixed command delays, and the board top calls it to read back displayed characters for self-check. The block only samples LCD_DATA. Tristating the inout bus is owned by the top, which releases its drivers whenever `bus_claim` is high.

## Interface
Parameters:
- T_AS, 3: cycles RS/RW are stable before EN rises (address setup, 60 ns at 50 MHz).
- T_EH, 13: cycles EN is high (260 ns). Data is sampled on the last of these cycles.
- T_EL, 13: cycles EN is low after the pulse (hold plus minimum E cycle time ≥500 ns).
- POLL_MAX, 2000: maximum busy-flag reads in poll mode before timeout.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- RST  in  1  synchronous, active-high reset.
- rd_req  in  1  start request; accepted only when `rd_ready`=1.
- rd_rs  in  1  register select for the read (0 = busy flag/address, 1 = data). Latched at accept.
- poll_en  in  1  poll mode; repeat status reads until BF=0. Latched at accept and forces RS=0.
- rd_ready  out  1  high in IDLE only.
- rd_valid  out  1  one-cycle pulse; `rd_data` and flags are valid in that cycle.
- rd_data  out  8  byte sampled from LCD_DATA_IN.
- busy_flag  out  1  equals rd_data[7] when the latched RS was 0; otherwise 0.
- addr_cnt  out  7  equals rd_data[6:0] when the latched RS was 0; otherwise 0.
- timeout  out  1  one-cycle pulse coincident with `rd_valid` when poll mode gave up.
- bus_claim  out  1  high from accept through the end of ELOW. The writer must tristate while this is high.
- LCD_RW  out  1  1 while `bus_claim` is high, else 0.
- LCD_RS  out  1  latched RS while `bus_claim` is high, else 0.
- LCD_EN  out  1  enable strobe.
- LCD_DATA_IN  in  8  LCD_DATA bus sampled by the top.

## Operation
- States: IDLE, SETUP, EHIGH, ELOW, DONE. One cycle counter, 5 bits, reloaded on each state entry. One 16-bit poll counter.
- IDLE: `rd_ready`=1. When `rd_req`=1, latch RS (0 if `poll_en`), latch `poll_en`, clear the poll counter, and go to SETUP.
- SETUP: LCD_EN=0 and LCD_RW=1 for T_AS cycles, then go to EHIGH.
- EHIGH: LCD_EN=1 for T_EH cycles. On the last cycle, register LCD_DATA_IN into `rd_data`, then go to ELOW.
- ELOW: LCD_EN=0 for T_EL cycles. Poll counter increments at ELOW exit. Exit rules:
  - Poll mode, rd_data[7]=1, and poll count < POLL_MAX: go back to SETUP with no `rd_valid`.
  - Poll mode, rd_data[7]=1, and POLL_MAX reads reached: go to DONE with timeout flagged.
  - All other cases: go to DONE.
- DONE: one cycle. `rd_valid`=1 (and `timeout` if flagged). `bus_claim` is 0. Next state is IDLE.
- `rd_req` is ignored outside IDLE and is not queued.
- `rd_data`, `busy_flag`, and `addr_cnt` hold their values until the next sample.

## Timing
- Reset values: state IDLE, `rd_ready`=1, all other outputs 0, both counters 0.
- `rd_req` is sampled at edge k.
  - SETUP: cycles k+1..k+3.
  - EHIGH: cycles k+4..k+16; sample at edge k+17.
  - ELOW: cycles k+17..k+29.
  - DONE: `rd_valid` at cycle k+30. Single-read latency is 30 cycles (T_AS+T_EH+T_EL+1).
  - `rd_ready` returns at cycle k+31.
- Each extra poll iteration adds 29 cycles (T_AS+T_EH+T_EL). `rd_valid` arrives at k+1+29·n, where n is the number of reads.
- LCD_RS and LCD_RW change only while LCD_EN=0. LCD_EN is never high outside EHIGH.
- Reset mid-operation: at the first edge with RST=1, go to IDLE; LCD_EN, `bus_claim`, and LCD_RW drop that edge; no `rd_valid` or `timeout`; `rd_data` clears.
- RST and `rd_req` high together: reset wins and the request is dropped.

## Test plan
- Single status read: `rd_req`=1, `rd_rs`=0, `poll_en`=0, LCD_DATA_IN=8'h25. Expect LCD_EN high for exactly 13 cycles starting at k+4; `rd_valid` at k+30; `rd_data`=8'h25, `busy_flag`=0, `addr_cnt`=7'h25.
- Data read: `rd_rs`=1, LCD_DATA_IN=8'hC1. Expect LCD_RS=1 throughout, `rd_data`=8'hC1, `busy_flag`=0, `addr_cnt`=0.
- Poll success: `poll_en`=1; bus model returns 8'h80 for 3 reads, then 8'h07. Expect 4 EN pulses, a single `rd_valid` at k+117, `busy_flag`=0, `addr_cnt`=7, no `timeout`.
- Poll timeout: POLL_MAX=4, bus stuck at 8'hFF. Expect 4 EN pulses, then `rd_valid` and `timeout` in the same cycle, with `busy_flag`=1.
- Reset mid-EHIGH: assert RST at k+8. Expect LCD_EN=0, `bus_claim`=0, `rd_ready`=1 after that edge, and no `rd_valid`. A new `rd_req` after reset completes normally.
- Request while busy: pulse `rd_req` at k+10 with `rd_rs`=1. Expect it to be ignored: LCD_RS stays at the first request's value and exactly one `rd_valid` occurs.

Source files
------------

// File: rtl/lcd_status_reader.sv
// lcd_status_reader
// Read-cycle engine for an HD44780-compatible LCD. Runs timed RW=1 cycles to
// fetch the busy flag / address counter (RS=0) or a data byte (RS=1). In poll
// mode it repeats status reads until BF=0 or the poll budget runs out.
//
// Handshake: a request is taken on any edge where rd_req=1 and rd_ready=1.
// The result is presented for exactly one cycle with rd_valid=1. There is no
// backpressure, and requests made while busy are dropped, not queued.
//
// Ports:
//   CLOCK_50     system clock
//   RST          synchronous active-high reset
//   rd_req       start request (taken only while rd_ready=1)
//   rd_rs        register select for the read, latched at accept
//   poll_en      poll mode, latched at accept; forces RS=0
//   rd_ready     high in IDLE only
//   rd_valid     one-cycle result strobe
//   rd_data      sampled LCD byte, held until the next sample
//   busy_flag    rd_data[7] for status reads, else 0
//   addr_cnt     rd_data[6:0] for status reads, else 0
//   timeout      with rd_valid when poll mode gave up
//   bus_claim    the top must release the LCD data drivers while this is high
//   LCD_RW       LCD read/write line
//   LCD_RS       LCD register select line
//   LCD_EN       LCD enable strobe
//   LCD_DATA_IN  LCD data bus as seen by the top
module lcd_status_reader #(
    parameter int T_AS     = 3,
    parameter int T_EH     = 13,
    parameter int T_EL     = 13,
    parameter int POLL_MAX = 2000
) (
    input  logic       CLOCK_50,
    input  logic       RST,
    input  logic       rd_req,
    input  logic       rd_rs,
    input  logic       poll_en,
    output logic       rd_ready,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       busy_flag,
    output logic [6:0] addr_cnt,
    output logic       timeout,
    output logic       bus_claim,
    output logic       LCD_RW,
    output logic       LCD_RS,
    output logic       LCD_EN,
    input  logic [7:0] LCD_DATA_IN
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        EHIGH = 3'd2,
        ELOW  = 3'd3,
        DONE  = 3'd4
    } state_t;

    // The cycle counter is loaded with (length - 1) on state entry and the
    // state is left on the cycle where it reads zero.
    localparam logic [4:0]  AS_LOAD    = 5'(T_AS - 1);
    localparam logic [4:0]  EH_LOAD    = 5'(T_EH - 1);
    localparam logic [4:0]  EL_LOAD    = 5'(T_EL - 1);
    localparam logic [15:0] POLL_MAX_W = 16'(POLL_MAX);

    state_t      state;
    logic [4:0]  cyc_cnt;
    logic [15:0] poll_cnt;
    logic        poll_q;
    logic [15:0] poll_next;

    // Number of reads completed once the current ELOW ends.
    assign poll_next = poll_cnt + 16'd1;

    always_ff @(posedge CLOCK_50) begin
        if (RST) begin
            state     <= IDLE;
            cyc_cnt   <= 5'd0;
            poll_cnt  <= 16'd0;
            poll_q    <= 1'b0;
            rd_ready  <= 1'b1;
            rd_valid  <= 1'b0;
            rd_data   <= 8'd0;
            busy_flag <= 1'b0;
            addr_cnt  <= 7'd0;
            timeout   <= 1'b0;
            bus_claim <= 1'b0;
            LCD_RW    <= 1'b0;
            LCD_RS    <= 1'b0;
            LCD_EN    <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            timeout  <= 1'b0;
            case (state)
                IDLE: begin
                    if (rd_req) begin
                        poll_q    <= poll_en;
                        LCD_RS    <= rd_rs & ~poll_en;
                        poll_cnt  <= 16'd0;
                        cyc_cnt   <= AS_LOAD;
                        bus_claim <= 1'b1;
                        LCD_RW    <= 1'b1;
                        rd_ready  <= 1'b0;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    if (cyc_cnt == 5'd0) begin
                        cyc_cnt <= EH_LOAD;
                        LCD_EN  <= 1'b1;
                        state   <= EHIGH;
                    end else begin
                        cyc_cnt <= cyc_cnt - 5'd1;
                    end
                end
                EHIGH: begin
                    if (cyc_cnt == 5'd0) begin
                        // Sample on the last EN-high cycle; LCD_RS still
                        // holds the RS used for this read.
                        rd_data   <= LCD_DATA_IN;
                        busy_flag <= ~LCD_RS & LCD_DATA_IN[7];
                        addr_cnt  <= LCD_RS ? 7'd0 : LCD_DATA_IN[6:0];
                        cyc_cnt   <= EL_LOAD;
                        LCD_EN    <= 1'b0;
                        state     <= ELOW;
                    end else begin
                        cyc_cnt <= cyc_cnt - 5'd1;
                    end
                end
                ELOW: begin
                    if (cyc_cnt == 5'd0) begin
                        poll_cnt <= poll_next;
                        if (poll_q && rd_data[7] && (poll_next < POLL_MAX_W)) begin
                            cyc_cnt <= AS_LOAD;
                            state   <= SETUP;
                        end else begin
                            rd_valid  <= 1'b1;
                            timeout   <= poll_q & rd_data[7];
                            bus_claim <= 1'b0;
                            LCD_RW    <= 1'b0;
                            LCD_RS    <= 1'b0;
                            state     <= DONE;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt - 5'd1;
                    end
                end
                DONE: begin
                    rd_ready <= 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    rd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
